// File: rtl/line_buffer_pingpong_pkg.sv
// Shared types and width helpers for the ping-pong line capture buffer.
package line_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } bank_state_t;

    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/line_buffer_pingpong_if.sv
// Camera-side pixel stream plus consumer read/release bundle for the line buffer.
// Handshake: RELEASE is a one-cycle pulse honoured only while LINE_READY is high;
// DATA_OUT answers READ_ADDRESS one cycle later and holds while LINE_READY is low.
interface line_buffer_pingpong_if
    import line_pkg::*;
#(
    parameter int COLUMNS = 752,
    parameter int LINES   = 480,
    parameter int DATA_W  = 8
);
    localparam int COL_W  = clog2_min1(COLUMNS);
    localparam int LINE_W = clog2_min1(LINES);

    logic              VALID_DATA;
    logic [COL_W-1:0]  CURRENT_COLUMN;
    logic [LINE_W-1:0] CURRENT_LINE;
    logic [DATA_W-1:0] DATA_IN;
    logic [LINE_W-1:0] FIRST_LINE;
    logic [LINE_W-1:0] LINE_STRIDE;
    logic [COL_W-1:0]  READ_ADDRESS;
    logic              RELEASE;
    logic              LINE_READY;
    logic [LINE_W-1:0] READY_LINE_NUMBER;
    logic [DATA_W-1:0] DATA_OUT;
    logic [7:0]        DROPPED_COUNT;
    logic              OVERFLOW;

    modport master (
        output VALID_DATA, CURRENT_COLUMN, CURRENT_LINE, DATA_IN,
        output FIRST_LINE, LINE_STRIDE, READ_ADDRESS, RELEASE,
        input  LINE_READY, READY_LINE_NUMBER, DATA_OUT, DROPPED_COUNT, OVERFLOW
    );

    modport slave (
        input  VALID_DATA, CURRENT_COLUMN, CURRENT_LINE, DATA_IN,
        input  FIRST_LINE, LINE_STRIDE, READ_ADDRESS, RELEASE,
        output LINE_READY, READY_LINE_NUMBER, DATA_OUT, DROPPED_COUNT, OVERFLOW
    );

endinterface

// File: rtl/line_buffer_pingpong_bank_ram.sv
// One line bank: simple dual-port RAM with synchronous write and registered read.
module line_bank_ram #(
    parameter int DEPTH  = 752,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    // Only the output register is reset; the array itself keeps stale data.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)  rdata_q <= '0;
        else if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/line_buffer_pingpong.sv
// Strided line capture into two ping-pong banks: one fills while the consumer reads the other.
module line_buffer_pingpong
    import line_pkg::*;
#(
    parameter int COLUMNS = 752,
    parameter int LINES   = 480,
    parameter int DATA_W  = 8
) (
    input logic CLK,
    input logic RST_N,
    line_buffer_pingpong_if.slave bus
);
    localparam int COL_W  = clog2_min1(COLUMNS);
    localparam int LINE_W = clog2_min1(LINES);

    bank_state_t       bank_q [2], bank_d [2];
    logic [LINE_W-1:0] tag_q [2], tag_d [2];
    logic              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LINE_W-1:0] target_q, target_d, stride_q, stride_d;
    logic              target_vld_q, target_vld_d;
    logic [7:0]        dropped_q, dropped_d;
    logic              overflow_q, overflow_d;
    logic              sel_q;

    logic              line_ready, rel, frame_start, line_sel, last_col, we;
    logic              eff_vld;
    logic [LINE_W-1:0] eff_target, eff_stride, new_stride;
    logic [LINE_W:0]   target_sum;
    bank_state_t       wr_state;
    logic [DATA_W-1:0] rdata [2];

    assign line_ready  = (bank_q[rd_ptr_q] == FULL);
    assign rel         = bus.RELEASE && line_ready;
    assign frame_start = bus.VALID_DATA && (bus.CURRENT_LINE == '0) && (bus.CURRENT_COLUMN == '0);
    assign new_stride  = (bus.LINE_STRIDE == '0) ? LINE_W'(1) : bus.LINE_STRIDE;
    // Frame-start latching is visible in the same cycle so line 0 can itself be selected.
    assign eff_target  = frame_start ? bus.FIRST_LINE : target_q;
    assign eff_stride  = frame_start ? new_stride : stride_q;
    assign eff_vld     = frame_start || target_vld_q;
    assign line_sel    = bus.VALID_DATA && (bus.CURRENT_COLUMN == '0) && eff_vld
                         && (bus.CURRENT_LINE == eff_target);
    assign last_col    = (bus.CURRENT_COLUMN == COL_W'(COLUMNS - 1));
    assign target_sum  = {1'b0, eff_target} + {1'b0, eff_stride};
    // A release in this cycle frees its bank before the write side looks at it.
    assign wr_state    = (rel && (rd_ptr_q == wr_ptr_q)) ? EMPTY : bank_q[wr_ptr_q];

    always_comb begin
        bank_d       = bank_q;
        tag_d        = tag_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        target_d     = target_q;
        target_vld_d = target_vld_q;
        stride_d     = stride_q;
        dropped_d    = dropped_q;
        overflow_d   = overflow_q;
        we           = 1'b0;

        if (rel) begin
            bank_d[rd_ptr_q] = EMPTY;
            rd_ptr_d         = ~rd_ptr_q;
        end
        if (frame_start) begin
            target_d     = bus.FIRST_LINE;
            stride_d     = new_stride;
            target_vld_d = 1'b1;
        end
        if (line_sel) begin
            if (wr_state != FULL) begin
                bank_d[wr_ptr_q] = FILLING;
                tag_d[wr_ptr_q]  = bus.CURRENT_LINE;
                we               = 1'b1;
            end else begin
                overflow_d = 1'b1;
                if (dropped_q != 8'hFF) dropped_d = dropped_q + 8'd1;
            end
            target_d     = target_sum[LINE_W-1:0];
            target_vld_d = (target_sum < (LINE_W+1)'(LINES));
        end else if (bus.VALID_DATA && (wr_state == FILLING)) begin
            we = 1'b1;
        end
        if (we && last_col) begin
            bank_d[wr_ptr_q] = FULL;
            wr_ptr_d         = ~wr_ptr_q;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            bank_q[0]    <= EMPTY;
            bank_q[1]    <= EMPTY;
            tag_q[0]     <= '0;
            tag_q[1]     <= '0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            target_q     <= '0;
            target_vld_q <= 1'b0;
            stride_q     <= LINE_W'(1);
            dropped_q    <= '0;
            overflow_q   <= 1'b0;
            sel_q        <= 1'b0;
        end else begin
            bank_q       <= bank_d;
            tag_q        <= tag_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            target_q     <= target_d;
            target_vld_q <= target_vld_d;
            stride_q     <= stride_d;
            dropped_q    <= dropped_d;
            overflow_q   <= overflow_d;
            if (line_ready) sel_q <= rd_ptr_q;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        line_bank_ram #(.DEPTH(COLUMNS), .DATA_W(DATA_W), .ADDR_W(COL_W)) u_ram (
            .clk_i   (CLK),
            .rst_n_i (RST_N),
            .we_i    (we && (wr_ptr_q == 1'(b))),
            .waddr_i (bus.CURRENT_COLUMN),
            .wdata_i (bus.DATA_IN),
            .re_i    (line_ready && (rd_ptr_q == 1'(b))),
            .raddr_i (bus.READ_ADDRESS),
            .rdata_o (rdata[b])
        );
    end

    assign bus.LINE_READY        = line_ready;
    assign bus.READY_LINE_NUMBER = tag_q[rd_ptr_q];
    assign bus.DATA_OUT          = rdata[sel_q];
    assign bus.DROPPED_COUNT     = dropped_q;
    assign bus.OVERFLOW          = overflow_q;
endmodule

// File: tb/tb_line_buffer_pingpong.sv
// Bench for line_buffer_pingpong on a tiny 2-column, 3-line frame.
module tb_line_buffer_pingpong;
  import line_pkg::*;

  localparam int COLUMNS = 2;
  localparam int LINES   = 3;
  localparam int DATA_W  = 8;
  localparam int COL_W   = clog2_min1(COLUMNS);
  localparam int LINE_W  = clog2_min1(LINES);

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [DATA_W-1:0] exp_q[$];

  line_buffer_pingpong_if #(.COLUMNS(COLUMNS), .LINES(LINES), .DATA_W(DATA_W)) bus ();

  line_buffer_pingpong #(.COLUMNS(COLUMNS), .LINES(LINES), .DATA_W(DATA_W)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // drivers
  task automatic drive_px(input int ln, input int col, input int val, input bit rel);
    bus.VALID_DATA     = 1'b1;
    bus.CURRENT_LINE   = LINE_W'(ln);
    bus.CURRENT_COLUMN = COL_W'(col);
    bus.DATA_IN        = DATA_W'(val);
    bus.RELEASE        = rel;
    @(posedge clk);
    #1;
    bus.VALID_DATA = 1'b0;
    bus.RELEASE    = 1'b0;
  endtask

  function automatic int pix(input int base, input int ln, input int col);
    return base + (ln + 1) * 10 + col + 1;
  endfunction

  task automatic send_frame(input int base, input bit rel_first);
    for (int l = 0; l < LINES; l++)
      for (int c = 0; c < COLUMNS; c++)
        drive_px(l, c, pix(base, l, c), rel_first && l == 0 && c == 0);
  endtask

  task automatic release_pulse();
    bus.RELEASE = 1'b1;
    @(posedge clk);
    #1 bus.RELEASE = 1'b0;
  endtask

  // scoreboard: expected pixel queued with the address, compared one cycle later
  task automatic read_px(input string tag, input int addr, input int expv);
    bus.READ_ADDRESS = COL_W'(addr);
    exp_q.push_back(DATA_W'(expv));
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) check_eq({tag, "_queue"}, 0, 1);
    else check_eq(tag, bus.DATA_OUT, exp_q.pop_front());
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ready"}, bus.LINE_READY, 0);
    check_eq({tag, "_rln"}, bus.READY_LINE_NUMBER, 0);
    check_eq({tag, "_dout"}, bus.DATA_OUT, 0);
    check_eq({tag, "_drop"}, bus.DROPPED_COUNT, 0);
    check_eq({tag, "_ovf"}, bus.OVERFLOW, 0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.VALID_DATA = 1'b0; bus.CURRENT_LINE = '0; bus.CURRENT_COLUMN = '0;
    bus.DATA_IN = '0; bus.READ_ADDRESS = '0; bus.RELEASE = 1'b0;
    bus.FIRST_LINE = LINE_W'(1); bus.LINE_STRIDE = LINE_W'(1);

    // first line 1, stride 1, no release
    apply_reset();
    check_reset_outputs("rst");
    send_frame(0, 1'b0);
    check_eq("t1_ready", bus.LINE_READY, 1);
    check_eq("t1_rln", bus.READY_LINE_NUMBER, 1);
    check_eq("t1_drop", bus.DROPPED_COUNT, 0);
    read_px("t1_rd0", 0, 21);
    read_px("t1_rd1", 1, 22);

    // release walks to the second bank, then empties
    release_pulse();
    check_eq("t2_ready", bus.LINE_READY, 1);
    check_eq("t2_rln", bus.READY_LINE_NUMBER, 2);
    read_px("t2_rd0", 0, 31);
    release_pulse();
    check_eq("t2_ready_lo", bus.LINE_READY, 0);
    bus.READ_ADDRESS = COL_W'(1);
    repeat (2) @(posedge clk);
    #1 check_eq("t2_dout_hold", bus.DATA_OUT, 31);
    release_pulse();
    check_eq("t2_rel_ignored", bus.LINE_READY, 0);

    // first line 0: third line dropped, then release coinciding with a line start
    bus.FIRST_LINE = '0;
    apply_reset();
    send_frame(0, 1'b0);
    check_eq("t3_drop", bus.DROPPED_COUNT, 1);
    check_eq("t3_ovf", bus.OVERFLOW, 1);
    check_eq("t3_rln", bus.READY_LINE_NUMBER, 0);
    read_px("t3_rd1", 1, 12);
    send_frame(100, 1'b1);
    check_eq("t3_drop_sim", bus.DROPPED_COUNT, 3);
    check_eq("t3_rln_sim", bus.READY_LINE_NUMBER, 1);
    read_px("t3_old_line1", 0, 21);
    release_pulse();
    check_eq("t3_rln_new", bus.READY_LINE_NUMBER, 0);
    read_px("t3_new_line0", 1, 112);
    for (int f = 0; f < 100; f++) send_frame(0, 1'b0);
    check_eq("t3_drop_sat", bus.DROPPED_COUNT, 255);
    check_eq("t3_ovf_sticky", bus.OVERFLOW, 1);

    // stride 2: lines 0 and 2 only, then target exhausted
    bus.LINE_STRIDE = LINE_W'(2);
    apply_reset();
    send_frame(0, 1'b0);
    check_eq("t4_drop", bus.DROPPED_COUNT, 0);
    check_eq("t4_rln0", bus.READY_LINE_NUMBER, 0);
    release_pulse();
    check_eq("t4_ready", bus.LINE_READY, 1);
    check_eq("t4_rln2", bus.READY_LINE_NUMBER, 2);
    read_px("t4_rd1", 1, 32);
    release_pulse();
    drive_px(2, 0, 77, 1'b0);
    drive_px(2, 1, 78, 1'b0);
    check_eq("t4_no_recapture", bus.LINE_READY, 0);

    // mid-frame stream at reset release is ignored until the next frame start
    bus.FIRST_LINE = LINE_W'(1); bus.LINE_STRIDE = LINE_W'(1);
    apply_reset();
    for (int l = 1; l < LINES; l++)
      for (int c = 0; c < COLUMNS; c++) begin
        drive_px(l, c, pix(0, l, c), 1'b0);
        check_eq("t5_ready_idle", bus.LINE_READY, 0);
      end
    send_frame(40, 1'b0);
    check_eq("t5_rln", bus.READY_LINE_NUMBER, 1);
    read_px("t5_rd0", 0, 61);

    // stride 0 acts as 1; async reset with one bank FULL and one FILLING
    bus.FIRST_LINE = '0; bus.LINE_STRIDE = '0;
    apply_reset();
    send_frame(0, 1'b0);
    check_eq("t6_drop", bus.DROPPED_COUNT, 1);
    read_px("t6_rd1", 1, 12);
    release_pulse();
    check_eq("t6_stride0_rln", bus.READY_LINE_NUMBER, 1);
    drive_px(0, 0, 200, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("t6_async");
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.FIRST_LINE = LINE_W'(1); bus.LINE_STRIDE = LINE_W'(1);
    send_frame(50, 1'b0);
    check_eq("t6_after_ready", bus.LINE_READY, 1);
    check_eq("t6_after_rln", bus.READY_LINE_NUMBER, 1);
    read_px("t6_after_rd0", 0, 71);
    check_eq("t6_after_drop", bus.DROPPED_COUNT, 0);

    check_eq("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
